// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
package pipe_pkg;

  // Occupancy of a stage buffer; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_e;

  // Instruction word that executes as a no-operation.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Bit offset of payload field k for a given field width.
  function automatic int unsigned field(input int unsigned k,
                                        input int unsigned data_w = 32);
    return k * data_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance only when requested and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with a 2-entry skid, flush and stall counting.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing held; out_valid=0
// ONE   | main register holds the head entry
// FULL2 | main holds the head, skid holds the next; in_ready=0
//
// in_ready depends only on the state flop, so no ready path runs
// combinationally from downstream to upstream.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_FIELDS  = 6,
  parameter int CLEAR_DATA  = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int PW = NUM_FIELDS * DATA_W;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic            in_fire;
  logic            out_fire;

  assign in_ready  = (state_q != FULL2);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next state and data moves; clear overrides the handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clear) begin
      state_d = EMPTY;
      if (CLEAR_DATA != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL2;
          end else if (out_fire) begin
            // main keeps its stale contents; out_valid hides it
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; reset always zeroes the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready & ~clear),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and randomised checks of pipe_stage_buf against a queue model.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int NF = 6;
  localparam int PW = DW * NF;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          out_ready;
  logic [PW-1:0] in_data;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [PW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;
  logic [15:0]   stall0;
  logic [3:0]    stall1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(DW), .NUM_FIELDS(NF), .CLEAR_DATA(1), .STALL_CNT_W(16)
  ) u0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  pipe_stage_buf #(
    .DATA_W(DW), .NUM_FIELDS(NF), .CLEAR_DATA(0), .STALL_CNT_W(4)
  ) u1 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs,
                     input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NF; k++) r[field(k) +: DW] = b + k;
    return r;
  endfunction

  function automatic logic [PW-1:0] rnd_payload();
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NF; k++) r[field(k) +: DW] = $urandom;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] pa, pb, pc, pd, instr_w;
    logic [PW-1:0] q[$];
    logic          m_in_fire, m_out_fire;
    logic [3:0]    sat_exp;

    pa = mk(32'h1111_1110);
    pb = mk(32'h2222_2220);
    pc = mk(32'hCCCC_CCC0);
    pd = mk(32'h9999_9990);

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0;
    #2;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_in_ready",  in_ready0, 1);
    chk("rst_occ",       occ0, 0);
    chk("rst_data",      out_data0, 0);
    chk("rst_stall",     stall0, 0);
    tick();
    reset = 1'b0;

    // streaming at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = mk(32'h3000 + 32'(4 * i));
      tick();
      chk("strm_valid", out_valid0, 1);
      chk("strm_data",  out_data0, mk(32'h3000 + 32'(4 * i)));
      chk("strm_occ",   occ0, 1);
      chk("strm_ready", in_ready0, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_drain_occ", occ0, 0);
    chk("strm_stall",     stall0, 0);

    // backpressure into the skid register
    in_valid = 1'b1; in_data = pa; out_ready = 1'b0;
    tick();
    chk("bp_a_data", out_data0, pa);
    chk("bp_a_occ",  occ0, 1);
    chk("bp_stall0", stall0, 0);
    in_data = pb;
    tick();
    chk("bp_full_occ",   occ0, 2);
    chk("bp_full_ready", in_ready0, 0);
    chk("bp_hold_a",     out_data0, pa);
    chk("bp_stall1",     stall0, 1);
    in_data = pd;
    tick();
    chk("bp_ign_occ",  occ0, 2);
    chk("bp_ign_data", out_data0, pa);
    chk("bp_stall2",   stall0, 2);
    chk("bp_stall2_w4", stall1, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_rel_b",   out_data0, pb);
    chk("bp_rel_occ", occ0, 1);
    chk("bp_rel_stall", stall0, 2);
    tick();
    chk("bp_empty_valid", out_valid0, 0);
    chk("bp_empty_ready", in_ready0, 1);

    // flush from FULL2 with an incoming payload
    in_valid = 1'b1; in_data = pa; out_ready = 1'b0;
    tick();
    in_data = pb;
    tick();
    chk("fl_pre_occ",   occ0, 2);
    chk("fl_pre_stall", stall0, 3);
    clear = 1'b1; in_data = pc;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("fl_occ",        occ0, 0);
    chk("fl_valid",      out_valid0, 0);
    chk("fl_data_zero",  out_data0, 0);
    instr_w = '0;
    instr_w[DW-1:0] = out_data0[field(1) +: DW];
    chk("fl_instr_nop",  instr_w, {{(PW-DW){1'b0}}, NOP_INSTR});
    chk("fl_stall_keep", stall0, 3);
    chk("fl_hold_valid", out_valid1, 0);
    chk("fl_hold_data",  out_data1, pa);
    tick();
    chk("fl_no_c", out_valid0, 0);

    // reset arriving between edges while FULL2
    in_valid = 1'b1; in_data = pa;
    tick();
    in_data = pb;
    tick();
    chk("mrst_pre_occ", occ0, 2);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_valid", out_valid0, 0);
    chk("mrst_occ",   occ0, 0);
    chk("mrst_data",  out_data0, 0);
    chk("mrst_stall", stall0, 0);
    chk("mrst_data1", out_data1, 0);
    tick();
    reset = 1'b0;

    // stall counter saturation (4-bit instance) vs unsaturated 16-bit
    in_valid = 1'b1; in_data = pa; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      sat_exp = (i > 15) ? 4'd15 : 4'(i);
      chk("sat_w4", stall1, sat_exp);
    end
    chk("sat_w16", stall0, 20);

    // random traffic against a queue model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q = {};
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rnd_payload();
      #1;
      chk("rnd_ready", in_ready0, (q.size() != 2));
      chk("rnd_occ",   occ0, q.size());
      chk("rnd_valid", out_valid0, (q.size() != 0));
      if (q.size() != 0) chk("rnd_data", out_data0, q[0]);
      m_in_fire  = in_valid && (q.size() != 2);
      m_out_fire = out_ready && (q.size() != 0);
      @(posedge clk);
      if (m_out_fire) void'(q.pop_front());
      if (m_in_fire)  q.push_back(in_data);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
